load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 168 ++++++++++++++++
 tb/tb_load_store_unit.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// RV32I load/store unit: one outstanding word-bus access per instruction,
// with lane steering, sign/zero extension, access checks and a bus timeout.
`timescale 1ns/1ps
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        load_valid,
  output logic [31:0] load_data,
  output logic        access_fault,
  output logic        bus_error,
  output logic        bus_req_valid,
  input  logic        bus_req_ready,
  output logic [31:0] bus_addr,
  output logic        bus_we,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_wdata,
  input  logic        bus_rsp_valid,
  input  logic [31:0] bus_rdata
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW:0] TMO = (CW + 1)'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    BUS_REQ,
    WAIT_RSP,
    DONE
  } state_t;

  state_t        state;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic          we_q;
  logic [2:0]    f3_q;
  logic [3:0]    strb_q;
  logic [CW-1:0] cnt;
  logic [CW:0]   cnt_inc;
  logic          tmo;
  logic          legal;
  logic [3:0]    strb_n;
  logic [31:0]   wdata_n;
  logic [7:0]    byte_s;
  logic [15:0]   half_s;
  logic [31:0]   ext;

  always_comb begin
    legal = 1'b0;
    case (req_funct3)
      3'b000, 3'b100: legal = 1'b1;
      3'b001, 3'b101: legal = ~req_addr[0];
      3'b010:         legal = (req_addr[1:0] == 2'b00);
      default:        legal = 1'b0;
    endcase
  end

  // Strobes and replicated data are computed up front and captured.
  always_comb begin
    strb_n  = 4'b1111;
    wdata_n = req_wdata;
    case (req_funct3[1:0])
      2'b00: begin
        strb_n  = 4'b0001 << req_addr[1:0];
        wdata_n = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        strb_n  = 4'b0011 << {req_addr[1], 1'b0};
        wdata_n = {2{req_wdata[15:0]}};
      end
      default: strb_n = 4'b1111;
    endcase
    if (!req_we) strb_n = 4'b0000;
  end

  always_comb begin
    byte_s = bus_rdata[{addr_q[1:0], 3'b000} +: 8];
    half_s = addr_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (f3_q)
      3'b000:  ext = {{24{byte_s[7]}}, byte_s};
      3'b100:  ext = {24'h0, byte_s};
      3'b001:  ext = {{16{half_s[15]}}, half_s};
      3'b101:  ext = {16'h0, half_s};
      default: ext = bus_rdata;
    endcase
  end

  assign cnt_inc = {1'b0, cnt} + 1'b1;
  assign tmo     = (cnt_inc >= TMO);

  assign stall = ~reset & ((state == IDLE & req_valid & legal)
                 | state == BUS_REQ | state == WAIT_RSP);

  assign bus_req_valid = (state == BUS_REQ);
  assign bus_addr      = {addr_q[31:2], 2'b00};
  assign bus_we        = we_q & (state == BUS_REQ);
  assign bus_wstrb     = bus_we ? strb_q : 4'b0000;
  assign bus_wdata     = wdata_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      we_q         <= 1'b0;
      f3_q         <= '0;
      strb_q       <= '0;
      cnt          <= '0;
      load_valid   <= 1'b0;
      load_data    <= '0;
      access_fault <= 1'b0;
      bus_error    <= 1'b0;
    end else begin
      access_fault <= 1'b0;
      bus_error    <= 1'b0;
      load_valid   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req_valid && legal) begin
            addr_q  <= req_addr;
            wdata_q <= wdata_n;
            we_q    <= req_we;
            f3_q    <= req_funct3;
            strb_q  <= strb_n;
            cnt     <= '0;
            state   <= BUS_REQ;
          end else if (req_valid) begin
            access_fault <= 1'b1;
          end
        end
        BUS_REQ: begin
          cnt <= cnt_inc[CW-1:0];
          if (bus_req_ready) begin
            state <= we_q ? DONE : WAIT_RSP;
          end else if (tmo) begin
            bus_error  <= 1'b1;
            load_data  <= '0;
            load_valid <= ~we_q;
            state      <= DONE;
          end
        end
        WAIT_RSP: begin
          cnt <= cnt_inc[CW-1:0];
          // A response in the timeout cycle still wins.
          if (bus_rsp_valid) begin
            load_data  <= ext;
            load_valid <= 1'b1;
            state      <= DONE;
          end else if (tmo) begin
            bus_error  <= 1'b1;
            load_data  <= '0;
            load_valid <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vector table, hand-written reset
// sequence and randomized accesses checked against a lane-level model.
`timescale 1ns/1ps
module tb_load_store_unit;

  localparam int TO = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall;
  logic        load_valid;
  logic [31:0] load_data;
  logic        access_fault;
  logic        bus_error;
  logic        bus_req_valid;
  logic        bus_req_ready;
  logic [31:0] bus_addr;
  logic        bus_we;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_wdata;
  logic        bus_rsp_valid;
  logic [31:0] bus_rdata;

  int checks = 0;
  int failures = 0;

  load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .stall(stall),
    .load_valid(load_valid), .load_data(load_data),
    .access_fault(access_fault), .bus_error(bus_error),
    .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready),
    .bus_addr(bus_addr), .bus_we(bus_we),
    .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata),
    .bus_rsp_valid(bus_rsp_valid), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          rdly;
    int          sdly;
    logic        fault;
    logic [31:0] baddr;
    logic [3:0]  strb;
    logic [31:0] bwdata;
    logic [31:0] ldata;
    logic        berr;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic we, input logic [2:0] f3, input logic [31:0] addr,
    input logic [31:0] wdata, input logic [31:0] rdata,
    input int rdly, input int sdly, input logic fault,
    input logic [31:0] baddr, input logic [3:0] strb,
    input logic [31:0] bwdata, input logic [31:0] ldata,
    input logic berr);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata;
    v.rdata = rdata; v.rdly = rdly; v.sdly = sdly;
    v.fault = fault; v.baddr = baddr; v.strb = strb;
    v.bwdata = bwdata; v.ldata = ldata; v.berr = berr;
    return v;
  endfunction

  // Reference model: access size, byte lanes and extension by arithmetic.
  function automatic vec_t model(
    input logic we, input logic [2:0] f3, input logic [31:0] addr,
    input logic [31:0] wdata, input logic [31:0] rdata);
    vec_t v;
    int sz;
    int lane;
    longint val;
    v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata;
    v.rdata = rdata; v.rdly = 0; v.sdly = 0; v.berr = 1'b0;
    case (f3)
      3'd0, 3'd4: sz = 1;
      3'd1, 3'd5: sz = 2;
      3'd2:       sz = 4;
      default:    sz = 0;
    endcase
    v.fault = (sz == 0) || ((addr % sz) != 0);
    lane = int'(addr % 4);
    v.baddr = addr - (addr % 4);
    v.strb = 4'b0000;
    v.bwdata = '0;
    val = 0;
    if (!v.fault) begin
      for (int i = 0; i < 4; i++) begin
        if (we && i >= lane && i < lane + sz) v.strb[i] = 1'b1;
        v.bwdata[8*i +: 8] = wdata[8*(i % sz) +: 8];
      end
      for (int k = 0; k < sz; k++)
        val += longint'(rdata[8*(lane+k) +: 8]) << (8*k);
      if (f3 == 3'd0 && val >= 128) val -= 256;
      if (f3 == 3'd1 && val >= 32768) val -= 65536;
    end
    v.ldata = 32'(val);
    return v;
  endfunction

  task automatic run_op(input vec_t v, input string nm);
    logic [31:0] a0, d0;
    logic [3:0]  s0;
    logic        w0;
    logic        lv, be;
    logic [31:0] ld;
    int sc, qc, rc, exp_sc;
    bit seen, stable, rsent, fin;
    @(negedge clk);
    req_valid = 1'b1; req_we = v.we; req_funct3 = v.f3;
    req_addr = v.addr; req_wdata = v.wdata; bus_rdata = v.rdata;
    #1;
    if (v.fault) begin
      chk({nm, ".stall_req"}, stall, 0);
      @(negedge clk);
      chk({nm, ".fault"}, access_fault, 1);
      chk({nm, ".req_valid"}, bus_req_valid, 0);
      req_valid = 1'b0;
      #1 chk({nm, ".stall_after"}, stall, 0);
      @(negedge clk);
      chk({nm, ".fault_pulse"}, access_fault, 0);
      chk({nm, ".no_bus"}, bus_req_valid, 0);
      return;
    end
    chk({nm, ".stall_req"}, stall, 1);
    sc = 0; qc = 0; rc = 0;
    seen = 0; stable = 1; rsent = 0; fin = 0;
    lv = 0; be = 0; ld = '0;
    a0 = '0; d0 = '0; s0 = '0; w0 = 0;
    for (int cyc = 0; cyc < TO + 10 && !fin; cyc++) begin
      @(negedge clk);
      bus_req_ready = 1'b0;
      bus_rsp_valid = 1'b0;
      if (stall) sc++;
      if (bus_req_valid) begin
        if (!seen) begin
          a0 = bus_addr; d0 = bus_wdata; s0 = bus_wstrb; w0 = bus_we;
          seen = 1;
        end else if (a0 !== bus_addr || d0 !== bus_wdata ||
                     s0 !== bus_wstrb || w0 !== bus_we || !stall) begin
          stable = 0;
        end
        if (qc >= v.rdly) bus_req_ready = 1'b1;
        qc++;
      end else if (!stall) begin
        fin = 1; lv = load_valid; ld = load_data; be = bus_error;
      end else if (!v.we && v.sdly >= 0 && !rsent) begin
        if (rc >= v.sdly) begin
          bus_rsp_valid = 1'b1;
          rsent = 1;
        end
        rc++;
      end
    end
    bus_req_ready = 1'b0;
    bus_rsp_valid = 1'b0;
    chk({nm, ".finished"}, fin, 1);
    chk({nm, ".req_seen"}, seen, 1);
    chk({nm, ".bus_addr"}, a0, v.baddr);
    chk({nm, ".bus_we"}, w0, v.we);
    chk({nm, ".bus_wstrb"}, s0, v.strb);
    if (v.we) chk({nm, ".bus_wdata"}, d0, v.bwdata);
    chk({nm, ".stable"}, stable, 1);
    exp_sc = v.rdly + 1 + (v.we ? 0 : (v.sdly < 0 ? TO : v.sdly + 1));
    if (exp_sc > TO) exp_sc = TO;
    chk({nm, ".stall_cycles"}, sc, exp_sc);
    chk({nm, ".load_valid"}, lv, !v.we);
    if (!v.we) chk({nm, ".load_data"}, ld, v.ldata);
    chk({nm, ".bus_error"}, be, v.berr);
    // Instruction is still presented across DONE and must not restart.
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk({nm, ".done_ignored"}, {bus_req_valid, stall, load_valid}, 0);
  endtask

  vec_t tbl[$];
  vec_t rv;
  logic [2:0] f3s[5];

  initial begin
    reset = 1'b1; req_valid = 1'b1; req_we = 1'b0;
    req_funct3 = 3'b010; req_addr = 32'h0; req_wdata = '0;
    bus_req_ready = 1'b0; bus_rsp_valid = 1'b0; bus_rdata = '0;
    f3s[0] = 3'd0; f3s[1] = 3'd1; f3s[2] = 3'd2;
    f3s[3] = 3'd4; f3s[4] = 3'd5;

    tbl.push_back(mk(0, 3'd0, 32'h103, 0, 32'h80FF1234, 0, 1,
                     0, 32'h100, 4'h0, 0, 32'hFFFFFF80, 0));
    tbl.push_back(mk(0, 3'd4, 32'h103, 0, 32'h80FF1234, 1, 0,
                     0, 32'h100, 4'h0, 0, 32'h00000080, 0));
    tbl.push_back(mk(1, 3'd1, 32'h202, 32'h0000ABCD, 0, 0, 0,
                     0, 32'h200, 4'hC, 32'hABCDABCD, 0, 0));
    tbl.push_back(mk(0, 3'd2, 32'h006, 0, 0, 0, 0,
                     1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 3'd2, 32'h040, 0, 32'hDEADBEEF, 3, 0,
                     0, 32'h040, 4'h0, 0, 32'hDEADBEEF, 0));
    tbl.push_back(mk(0, 3'd1, 32'h102, 0, 32'h80FF1234, 0, 2,
                     0, 32'h100, 4'h0, 0, 32'hFFFF80FF, 0));
    tbl.push_back(mk(0, 3'd5, 32'h100, 0, 32'h80FF1234, 2, 0,
                     0, 32'h100, 4'h0, 0, 32'h00001234, 0));
    tbl.push_back(mk(1, 3'd0, 32'h301, 32'h123456A5, 0, 2, 0,
                     0, 32'h300, 4'h2, 32'hA5A5A5A5, 0, 0));
    tbl.push_back(mk(1, 3'd2, 32'h404, 32'hCAFEF00D, 0, 0, 0,
                     0, 32'h404, 4'hF, 32'hCAFEF00D, 0, 0));
    tbl.push_back(mk(1, 3'd0, 32'h303, 32'h000000FF, 0, 1, 0,
                     0, 32'h300, 4'h8, 32'hFFFFFFFF, 0, 0));
    tbl.push_back(mk(0, 3'd1, 32'h001, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 3'd3, 32'h000, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 3'd2, 32'h402, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 3'd7, 32'h000, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 3'd0, 32'h100, 0, 32'h0000007F, 0, 0,
                     0, 32'h100, 4'h0, 0, 32'h0000007F, 0));
    tbl.push_back(mk(0, 3'd2, 32'h044, 0, 32'h55555555, 0, -1,
                     0, 32'h044, 4'h0, 0, 32'h00000000, 1));
    tbl.push_back(mk(0, 3'd2, 32'h048, 0, 32'h13579BDF, 0, TO - 2,
                     0, 32'h048, 4'h0, 0, 32'h13579BDF, 0));

    // Reset state, with a legal request presented during reset.
    repeat (2) @(negedge clk);
    chk("rst.stall", stall, 0);
    chk("rst.outs", {bus_req_valid, load_valid, access_fault,
                     bus_error, bus_we, bus_wstrb}, 0);
    chk("rst.load_data", load_data, 0);
    chk("rst.bus_addr", bus_addr, 0);
    req_valid = 1'b0;
    reset = 1'b0;
    @(negedge clk);

    foreach (tbl[i]) run_op(tbl[i], $sformatf("vec%0d", i));

    // Reset while waiting for a response; late response must be dropped.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010;
    req_addr = 32'h80; bus_rdata = 32'hA5A5A5A5;
    @(negedge clk);
    chk("rw.bus_req", bus_req_valid, 1);
    bus_req_ready = 1'b1;
    @(negedge clk);
    bus_req_ready = 1'b0;
    chk("rw.waiting", {stall, bus_req_valid}, 2'b10);
    reset = 1'b1;
    #1 chk("rw.stall_in_reset", stall, 0);
    @(negedge clk);
    chk("rw.after_rst", {bus_req_valid, load_valid, stall}, 0);
    chk("rw.load_data", load_data, 0);
    req_valid = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    bus_rsp_valid = 1'b1;
    @(negedge clk);
    bus_rsp_valid = 1'b0;
    chk("rw.rsp_ignored", {load_valid, stall, bus_req_valid}, 0);
    @(negedge clk);
    chk("rw.rsp_ignored2", {load_valid, stall, bus_error}, 0);
    chk("rw.load_data2", load_data, 0);

    // Randomized accesses against the reference model.
    for (int n = 0; n < 60; n++) begin
      logic [2:0]  f3;
      logic [31:0] a;
      if ($urandom_range(7) == 0) f3 = 3'($urandom_range(7));
      else f3 = f3s[$urandom_range(4)];
      a = $urandom;
      if ($urandom_range(1) == 1) a[1:0] = 2'b00;
      rv = model(1'($urandom_range(1)), f3, a, $urandom, $urandom);
      rv.rdly = $urandom_range(3);
      rv.sdly = $urandom_range(3);
      run_op(rv, $sformatf("rnd%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
